clock_period_meter: RTL and testbench

//  Measures a slow, asynchronous square wave (measuredClock) in cycles of inputClock.

---
 rtl/musicbox_pkg.sv | 4 +
 rtl/clock_period_meter_if.sv | 9 +
 rtl/clock_period_meter_sync.sv | 30 +++
 rtl/clock_period_meter.sv | 128 ++++++++++++
 tb/tb_clock_period_meter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/musicbox_pkg.sv
// musicbox_pkg: shared types for the music-box tone path
package musicbox_pkg;
    typedef enum logic [1:0] {PM_IDLE, PM_ARM, PM_MEASURE, PM_HOLD} period_meter_state_t;
endpackage

// File: rtl/clock_period_meter_if.sv
// clock_period_meter_if: measurement result channel with valid/ready handshake
interface clock_period_meter_if #(parameter int CountBits = 24) ();
    logic [CountBits-1:0] period_count;
    logic [CountBits-1:0] high_count;
    logic                 result_valid;
    logic                 result_ready;
    modport master (output period_count, high_count, result_valid, input result_ready);
    modport slave (input period_count, high_count, result_valid, output result_ready);
endinterface

// File: rtl/clock_period_meter_sync.sv
// edge_synchronizer: multi-flop synchronizer for a slow async input with rise/fall strobes
module edge_synchronizer #(
    parameter int Stages = 2
) (
    input  logic inputClock,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);
    logic [Stages-1:0] sync_q, sync_d;
    logic              sync_dly_q, sync_dly_d;
    always_comb begin
        sync_d     = {sync_q[Stages-2:0], async_in};
        sync_dly_d = sync_q[Stages-1];
    end
    always_ff @(posedge inputClock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sync_dly_q <= sync_dly_d;
        end
    end
    assign sync_out = sync_q[Stages-1];
    assign rise     = sync_out & ~sync_dly_q;
    assign fall     = ~sync_out & sync_dly_q;
endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow async square wave in inputClock cycles
module clock_period_meter
    import musicbox_pkg::*;
#(
    parameter int                   CountBits  = 24,
    parameter logic [CountBits-1:0] MaxCount   = 24'hFFFFFF,
    parameter int                   SyncStages = 2
) (
    input  logic                   inputClock,
    input  logic                   reset_n,
    input  logic                   measuredClock,
    input  logic                   enable,
    clock_period_meter_if.master   res,
    output logic                   timeout,
    output logic                   busy
);
    period_meter_state_t  state_q, state_d;
    logic [CountBits-1:0] cnt_q, cnt_d;
    logic [CountBits-1:0] high_cnt_q, high_cnt_d;
    logic [CountBits-1:0] period_q, period_d;
    logic [CountBits-1:0] high_q, high_d;
    logic                 high_done_q, high_done_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;
    logic                 sync, rise, fall;

    edge_synchronizer #(.Stages(SyncStages)) u_sync (
        .inputClock(inputClock),
        .reset_n(reset_n),
        .async_in(measuredClock),
        .sync_out(sync),
        .rise(rise),
        .fall(fall)
    );

    // cnt doubles as the timeout wait counter in ARM and as the period counter in MEASURE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_cnt_d  = high_cnt_q;
        high_done_d = high_done_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = valid_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            PM_IDLE: begin
                cnt_d   = '0;
                state_d = enable ? PM_ARM : PM_IDLE;
            end
            PM_ARM: begin
                if (!enable) begin
                    state_d = PM_IDLE;
                end else if (rise) begin
                    state_d     = PM_MEASURE;
                    cnt_d       = CountBits'(1);
                    high_cnt_d  = '0;
                    high_done_d = 1'b0;
                end else if (cnt_q == MaxCount) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    high_d    = '0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PM_MEASURE: begin
                if (!enable) begin
                    state_d = PM_IDLE;
                end else if (rise) begin
                    period_d = cnt_q;
                    high_d   = high_done_q ? high_cnt_q : cnt_q;
                    valid_d  = 1'b1;
                    state_d  = PM_HOLD;
                end else if (cnt_q == MaxCount) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    high_d    = '0;
                    cnt_d     = '0;
                    state_d   = PM_ARM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (fall && !high_done_q) begin
                        high_cnt_d  = cnt_q;
                        high_done_d = 1'b1;
                    end
                end
            end
            PM_HOLD: begin
                if (valid_q && res.result_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = enable ? PM_ARM : PM_IDLE;
                end
            end
            default: state_d = PM_IDLE;
        endcase
    end

    always_ff @(posedge inputClock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PM_IDLE;
            cnt_q       <= '0;
            high_cnt_q  <= '0;
            high_done_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_cnt_q  <= high_cnt_d;
            high_done_q <= high_done_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign res.period_count = period_q;
    assign res.high_count   = high_q;
    assign res.result_valid = valid_q;
    assign timeout          = timeout_q;
    assign busy             = (state_q == PM_ARM) || (state_q == PM_MEASURE);
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed scoreboard bench for clock_period_meter
module tb_clock_period_meter;
    import musicbox_pkg::*;

    typedef struct {int p_lo; int p_hi; int h_lo; int h_hi;} exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic enable = 1'b0;
    logic timeout, busy, meas;
    logic sgen = 1'b0;
    logic agen = 1'b0;
    logic mon = 1'b0;
    logic vseen = 1'b0;
    int   mode = 0;
    int   gcnt = 0;
    int   cyc = 0;
    int   xfers = 0;
    int   checks = 0;
    int   failures = 0;
    int   tq[$];
    exp_t sb[$];

    clock_period_meter_if #(.CountBits(24)) bus ();

    clock_period_meter #(.CountBits(24), .MaxCount(24'd1000), .SyncStages(2)) dut (
        .inputClock(clk),
        .reset_n(reset_n),
        .measuredClock(meas),
        .enable(enable),
        .res(bus),
        .timeout(timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always #2503 agen = ~agen;
    assign meas = (mode == 1) ? sgen : (mode == 2) ? agen : 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.result_valid && bus.result_ready) xfers <= xfers + 1;
        if (gcnt == 4) begin
            gcnt <= 0;
            sgen <= ~sgen;
        end else begin
            gcnt <= gcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (mon && timeout) tq.push_back(cyc);
        if (mon && bus.result_valid) vseen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic get_result(input string tag, input int budget);
        exp_t e;
        int   n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.result_valid && n < budget);
        check({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
        if (bus.result_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check_range({tag, "_period"}, int'(bus.period_count), e.p_lo, e.p_hi);
            check_range({tag, "_high"}, int'(bus.high_count), e.h_lo, e.h_hi);
        end
    endtask

    initial begin
        logic [23:0] hp, hh, last_p;
        logic        stable, no_valid;
        int          xb, n;
        bus.result_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_period", 32'(bus.period_count), 32'd0);
        check("rst_high", 32'(bus.high_count), 32'd0);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        mode = 1;
        bus.result_ready = 1'b1;
        repeat (3) sb.push_back('{10, 10, 5, 5});
        enable = 1'b1;
        get_result("sync0", 100);
        get_result("sync1", 100);
        get_result("sync2", 100);
        @(negedge clk);

        bus.result_ready = 1'b0;
        sb.push_back('{10, 10, 5, 5});
        get_result("hold", 100);
        hp = bus.period_count;
        hh = bus.high_count;
        stable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            stable &= bus.result_valid && bus.period_count == hp && bus.high_count == hh;
        end
        check("hold_stable", 32'(stable), 32'd1);
        xb = xfers;
        bus.result_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", 32'(bus.result_valid), 32'd0);
        check("hold_rearm_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("hold_one_xfer", 32'(xfers), 32'(xb + 1));

        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        mode = 2;
        repeat (2) sb.push_back('{500, 501, 250, 251});
        enable = 1'b1;
        get_result("async0", 3000);
        get_result("async1", 3000);
        last_p = bus.period_count;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dut.state_q != PM_MEASURE && n < 3000);
        check("reach_measure", 32'(dut.state_q), 32'(PM_MEASURE));
        repeat (100) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("drop_state_idle", 32'(dut.state_q), 32'(PM_IDLE));
        check("drop_busy", 32'(busy), 32'd0);
        no_valid = 1'b1;
        repeat (600) begin
            @(negedge clk);
            no_valid &= !bus.result_valid;
        end
        check("drop_no_valid", 32'(no_valid), 32'd1);
        check("drop_hold_last", 32'(bus.period_count), 32'(last_p));
        sb.push_back('{500, 501, 250, 251});
        enable = 1'b1;
        get_result("after_drop", 3000);

        enable = 1'b0;
        mode = 0;
        repeat (6) @(negedge clk);
        mon = 1'b1;
        enable = 1'b1;
        repeat (3500) @(negedge clk);
        mon = 1'b0;
        check_range("to_pulses", tq.size(), 3, 4);
        for (int i = 1; i < tq.size(); i++) check_range("to_interval", tq[i] - tq[i-1], 1000, 1002);
        check("to_no_valid", 32'(vseen), 32'd0);
        check("to_period_zero", 32'(bus.period_count), 32'd0);
        check("to_high_zero", 32'(bus.high_count), 32'd0);

        enable = 1'b0;
        @(negedge clk);
        mode = 1;
        bus.result_ready = 1'b0;
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.result_valid && n < 200);
        check("hold_before_reset", 32'(bus.result_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_period", 32'(bus.period_count), 32'd0);
        check("arst_high", 32'(bus.high_count), 32'd0);
        check("arst_valid", 32'(bus.result_valid), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_state", 32'(dut.state_q), 32'(PM_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
